sudoku_solver_gen: RTL

- Parametrised successor to the fixed 9x9 one-hot backtracking solver; handles any BOX×BOX-boxed grid (4x4, 9x9, 16x16).
- Keeps incremental row/column/box occupancy masks, so each TRY cycle jumps straight to the lowest legal candidate instead of testing values one at a time.
- Adds an addressed load/read port, load-time conflict detection and cycle/backtrack counters.
- Sits between the board-entry/display front end and the status LEDs/SSDs.

---
 rtl/sudoku_pkg.sv | 42 ++++
 rtl/sudoku_cand_pick.sv | 37 +++
 rtl/sudoku_solver_gen.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ===== sudoku_pkg: solver state encoding, width helpers, one-hot/binary conversion ===== Rev 1.0
package sudoku_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    TRY  = 3'd2,
    BACK = 3'd3,
    DONE = 3'd4,
    FAIL = 3'd5
  } state_t;

  localparam int MAX_SIDE = 16;

  function automatic int calc_aw(input int box);
    return $clog2(box * box);
  endfunction

  function automatic int calc_vw(input int box);
    return $clog2(box * box + 1);
  endfunction

  function automatic logic [MAX_SIDE-1:0] bin_to_onehot(input logic [4:0] v);
    logic [MAX_SIDE-1:0] oh;
    oh = '0;
    if (v != 5'd0 && v <= 5'd16) oh[4'(v - 5'd1)] = 1'b1;
    return oh;
  endfunction

  // Lowest set bit wins; zero input maps to 0 (empty cell).
  function automatic logic [4:0] onehot_to_bin(input logic [MAX_SIDE-1:0] oh);
    logic [4:0] v;
    v = '0;
    for (int i = MAX_SIDE - 1; i >= 0; i--) begin
      if (oh[i]) v = 5'(i + 1);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sudoku_cand_pick.sv
`default_nettype none
// ===== sudoku_cand_pick: lowest available candidate strictly above a floor value ===== Rev 1.0
module sudoku_cand_pick
  import sudoku_pkg::*;
#(
  parameter int SIDE = 9,
  parameter int VW   = 4
) (
  input  logic [SIDE-1:0] avail,
  input  logic [VW-1:0]   floor_val,
  output logic [SIDE-1:0] pick,
  output logic            found
);

  logic [SIDE-1:0] above;
  logic [SIDE-1:0] masked;

  // Bit i encodes value i+1, so "above floor" means i >= floor.
  for (genvar i = 0; i < SIDE; i++) begin : g_above
    assign above[i] = (i >= int'(floor_val));
  end

  assign masked = avail & above;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < SIDE; i++) begin
      if (masked[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sudoku_solver_gen.sv
`default_nettype none
// ===== sudoku_solver_gen: BOXxBOX backtracking solver with occupancy masks; SUDOKU_SINGLE_STEP_EN adds Single/Step ===== Rev 1.0
module sudoku_solver_gen
  import sudoku_pkg::*;
#(
  parameter int  BOX  = 3,
  parameter int  CW   = 32,
  localparam int SIDE = BOX * BOX,
  localparam int AW   = calc_aw(BOX),
  localparam int VW   = calc_vw(BOX)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Clear,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadRow,
  input  logic [AW-1:0] LoadCol,
  input  logic [VW-1:0] LoadValue,
  input  logic          Start,
`ifdef SUDOKU_SINGLE_STEP_EN
  input  logic          Single,
  input  logic          Step,
`endif
  input  logic [AW-1:0] RdRow,
  input  logic [AW-1:0] RdCol,
  output logic [VW-1:0] RdValue,
  output logic          RdFixed,
  output logic          Busy,
  output logic          Done,
  output logic          Fail,
  output logic          LoadErr,
  output logic [AW-1:0] CurRow,
  output logic [AW-1:0] CurCol,
  output logic [CW-1:0] Cycles,
  output logic [CW-1:0] Backtracks
);

  localparam int CELLS = SIDE * SIDE;
  localparam int IW    = $clog2(CELLS);

  function automatic logic [IW-1:0] cell_of(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return IW'(int'(r) * SIDE + int'(c));
  endfunction

  function automatic logic [AW-1:0] box_of(input logic [AW-1:0] r, input logic [AW-1:0] c);
    return AW'((int'(r) / BOX) * BOX + int'(c) / BOX);
  endfunction

  state_t          state, state_nxt;
  logic [SIDE-1:0] board    [CELLS];
  logic [CELLS-1:0] fixed;
  logic [SIDE-1:0] row_used [SIDE];
  logic [SIDE-1:0] col_used [SIDE];
  logic [SIDE-1:0] box_used [SIDE];
  logic [SIDE-1:0] fix_row  [SIDE];
  logic [SIDE-1:0] fix_col  [SIDE];
  logic [SIDE-1:0] fix_box  [SIDE];
  logic [AW-1:0]   cur_row, cur_col, nxt_row, nxt_col;
  logic [VW-1:0]   floor_val, floor_nxt;
  logic            load_err;
  logic [CW-1:0]   cycles, backtracks;

  logic [IW-1:0]   cur_cell, ld_cell, rd_cell, wr_cell;
  logic [AW-1:0]   cur_box, ld_box, wr_row, wr_col, wr_box;
  logic [AW-1:0]   fwd_row, fwd_col, prv_row, prv_col;
  logic            cur_fixed, is_first, is_last, advance;
  logic [SIDE-1:0] cur_val, cand_pick, ld_oh, ld_used, wr_new, wr_old;
  logic            cand_found, ld_in_range, rd_in_range, ld_conflict;
  logic            wr_en, fix_wr, fix_new, err_set, clear_all, clear_free, ctr_clr, bt_inc, cyc_inc;

  assign cur_cell  = cell_of(cur_row, cur_col);
  assign cur_box   = box_of(cur_row, cur_col);
  assign cur_fixed = fixed[cur_cell];
  assign cur_val   = board[cur_cell];
  assign is_first  = (cur_row == '0) && (cur_col == '0);
  assign is_last   = (cur_row == AW'(SIDE - 1)) && (cur_col == AW'(SIDE - 1));
  assign fwd_col   = (cur_col == AW'(SIDE - 1)) ? '0 : cur_col + 1'b1;
  assign fwd_row   = (cur_col == AW'(SIDE - 1)) ? cur_row + 1'b1 : cur_row;
  assign prv_col   = (cur_col == '0) ? AW'(SIDE - 1) : cur_col - 1'b1;
  assign prv_row   = (cur_col == '0) ? cur_row - 1'b1 : cur_row;

`ifdef SUDOKU_SINGLE_STEP_EN
  assign advance = !Single || Step;
`else
  assign advance = 1'b1;
`endif

  sudoku_cand_pick #(
    .SIDE(SIDE),
    .VW  (VW)
  ) u_pick (
    .avail    (~(row_used[cur_row] | col_used[cur_col] | box_used[cur_box])),
    .floor_val(floor_val),
    .pick     (cand_pick),
    .found    (cand_found)
  );

  // Load conflict ignores the target cell's own value so rewriting a cell is legal.
  assign ld_in_range = (int'(LoadRow) < SIDE) && (int'(LoadCol) < SIDE);
  assign ld_cell     = cell_of(LoadRow, LoadCol);
  assign ld_box      = box_of(LoadRow, LoadCol);
  assign ld_oh       = SIDE'(bin_to_onehot(5'(LoadValue)));
  assign ld_used     = (row_used[LoadRow] | col_used[LoadCol] | box_used[ld_box]) & ~board[ld_cell];
  assign ld_conflict = (int'(LoadValue) > SIDE) || (|(ld_used & ld_oh));

  assign rd_in_range = (int'(RdRow) < SIDE) && (int'(RdCol) < SIDE);
  assign rd_cell     = cell_of(RdRow, RdCol);
  assign RdValue     = rd_in_range ? VW'(onehot_to_bin(16'(board[rd_cell]))) : '0;
  assign RdFixed     = rd_in_range ? fixed[rd_cell] : 1'b0;

  assign wr_old = board[wr_cell];

  // Masks contributed by givens alone, used to restore after a retry-clear.
  always_comb begin
    for (int r = 0; r < SIDE; r++) begin
      fix_row[r] = '0;
      fix_col[r] = '0;
      fix_box[r] = '0;
    end
    for (int r = 0; r < SIDE; r++) begin
      for (int c = 0; c < SIDE; c++) begin
        if (fixed[r * SIDE + c]) begin
          fix_row[r] = fix_row[r] | board[r * SIDE + c];
          fix_col[c] = fix_col[c] | board[r * SIDE + c];
          fix_box[(r / BOX) * BOX + c / BOX] = fix_box[(r / BOX) * BOX + c / BOX] | board[r * SIDE + c];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    nxt_row    = cur_row;
    nxt_col    = cur_col;
    floor_nxt  = floor_val;
    wr_en      = 1'b0;
    wr_cell    = cur_cell;
    wr_row     = cur_row;
    wr_col     = cur_col;
    wr_box     = cur_box;
    wr_new     = '0;
    fix_wr     = 1'b0;
    fix_new    = 1'b0;
    err_set    = 1'b0;
    clear_all  = 1'b0;
    clear_free = 1'b0;
    ctr_clr    = 1'b0;
    bt_inc     = 1'b0;
    if (Clear) begin
      clear_all = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (LoadEn) begin
            wr_cell = ld_cell;
            wr_row  = LoadRow;
            wr_col  = LoadCol;
            wr_box  = ld_box;
            if (ld_in_range) begin
              if (LoadValue == '0) begin
                wr_en  = 1'b1;
                fix_wr = 1'b1;
              end else if (ld_conflict) begin
                err_set = 1'b1;
              end else begin
                wr_en   = 1'b1;
                wr_new  = ld_oh;
                fix_wr  = 1'b1;
                fix_new = 1'b1;
              end
            end
          end else if (Start && !load_err) begin
            nxt_row   = '0;
            nxt_col   = '0;
            floor_nxt = '0;
            ctr_clr   = 1'b1;
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          if (advance) begin
            if (!cur_fixed) begin
              floor_nxt = '0;
              state_nxt = TRY;
            end else if (is_last) begin
              state_nxt = DONE;
            end else begin
              nxt_row = fwd_row;
              nxt_col = fwd_col;
            end
          end
        end
        TRY: begin
          if (advance) begin
            if (cand_found) begin
              wr_en  = 1'b1;
              wr_new = cand_pick;
              if (is_last) begin
                state_nxt = DONE;
              end else begin
                nxt_row   = fwd_row;
                nxt_col   = fwd_col;
                state_nxt = SCAN;
              end
            end else if (is_first) begin
              state_nxt = FAIL;
            end else begin
              nxt_row   = prv_row;
              nxt_col   = prv_col;
              bt_inc    = 1'b1;
              state_nxt = BACK;
            end
          end
        end
        BACK: begin
          if (advance) begin
            if (!cur_fixed) begin
              floor_nxt = VW'(onehot_to_bin(16'(cur_val)));
              wr_en     = 1'b1;
              state_nxt = TRY;
            end else if (is_first) begin
              state_nxt = FAIL;
            end else begin
              nxt_row = prv_row;
              nxt_col = prv_col;
            end
          end
        end
        DONE, FAIL: begin
          if (Start) begin
            clear_free = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cyc_inc = Busy && advance && !Clear;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CELLS; i++) board[i] <= '0;
      for (int i = 0; i < SIDE; i++) begin
        row_used[i] <= '0;
        col_used[i] <= '0;
        box_used[i] <= '0;
      end
      fixed      <= '0;
      cur_row    <= '0;
      cur_col    <= '0;
      floor_val  <= '0;
      load_err   <= 1'b0;
      cycles     <= '0;
      backtracks <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < CELLS; i++) board[i] <= '0;
      for (int i = 0; i < SIDE; i++) begin
        row_used[i] <= '0;
        col_used[i] <= '0;
        box_used[i] <= '0;
      end
      fixed      <= '0;
      cur_row    <= '0;
      cur_col    <= '0;
      floor_val  <= '0;
      load_err   <= 1'b0;
      cycles     <= '0;
      backtracks <= '0;
    end else if (clear_free) begin
      for (int i = 0; i < CELLS; i++) begin
        if (!fixed[i]) board[i] <= '0;
      end
      for (int i = 0; i < SIDE; i++) begin
        row_used[i] <= fix_row[i];
        col_used[i] <= fix_col[i];
        box_used[i] <= fix_box[i];
      end
    end else begin
      if (wr_en) begin
        board[wr_cell]   <= wr_new;
        row_used[wr_row] <= (row_used[wr_row] & ~wr_old) | wr_new;
        col_used[wr_col] <= (col_used[wr_col] & ~wr_old) | wr_new;
        box_used[wr_box] <= (box_used[wr_box] & ~wr_old) | wr_new;
      end
      if (fix_wr)  fixed[wr_cell] <= fix_new;
      if (err_set) load_err <= 1'b1;
      cur_row   <= nxt_row;
      cur_col   <= nxt_col;
      floor_val <= floor_nxt;
      if (ctr_clr) begin
        cycles     <= '0;
        backtracks <= '0;
      end else begin
        if (cyc_inc && cycles != '1)    cycles     <= cycles + 1'b1;
        if (bt_inc && backtracks != '1) backtracks <= backtracks + 1'b1;
      end
    end
  end

  assign Busy       = (state == SCAN) || (state == TRY) || (state == BACK);
  assign Done       = (state == DONE);
  assign Fail       = (state == FAIL);
  assign LoadErr    = load_err;
  assign CurRow     = cur_row;
  assign CurCol     = cur_col;
  assign Cycles     = cycles;
  assign Backtracks = backtracks;

endmodule
`default_nettype wire
